// File: rtl/clk_switch_pkg.sv
// Shared types and helpers for the clock-source switch controller.
// Holds the FSM state encoding, source constants and owner-width helper.
package clk_switch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSwitch,
    StDone,
    StHold
  } state_e;

  localparam logic SRC_CLK0 = 1'b0;
  localparam logic SRC_CLK1 = 1'b1;

  // A single requester still needs a 1-bit owner field.
  function automatic int unsigned owner_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_switch_ctrl_if.sv
// Requester-side bundle of the clock switch controller: request/ack handshake
// plus the mux select and status outputs.
interface clk_switch_ctrl_if #(
  parameter int unsigned NUM_REQ = 4
);
  import clk_switch_pkg::*;

  localparam int unsigned OwnW = owner_width(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_src;
  logic [NUM_REQ-1:0] ack;
  logic               sel;
  logic               cur_src;
  logic               busy;
  logic [OwnW-1:0]    owner;

  modport master (
    output req, req_src,
    input  ack, sel, cur_src, busy, owner
  );

  modport slave (
    input  req, req_src,
    output ack, sel, cur_src, busy, owner
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i
// wins. The pointer register lives in the parent.
module rr_arbiter
  import clk_switch_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned OwnW = owner_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [OwnW-1:0]    ptr_i,
  output logic               grant_valid_o,
  output logic [OwnW-1:0]    grant_o
);

  localparam logic [OwnW:0] NumReqW = (OwnW + 1)'(NUM_REQ);

  logic [OwnW:0]   sum;
  logic [OwnW-1:0] idx;

  always_comb begin
    grant_valid_o = 1'b0;
    grant_o       = '0;
    sum           = '0;
    idx           = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // ptr_i < NUM_REQ, so one conditional subtract is a full modulo.
      sum = {1'b0, ptr_i} + (OwnW + 1)'(i);
      if (sum >= NumReqW) begin
        sum = sum - NumReqW;
      end
      idx = sum[OwnW-1:0];
      if (!grant_valid_o && req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_o       = idx;
      end
    end
  end

endmodule

// File: rtl/clk_switch_ctrl.sv
// Sequences the glitch-free clk0/clk1 mux: grants requests round-robin, drives
// sel, waits a settle interval, acks, then enforces a minimum dwell.
module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned HOLD_CYC   = 16,
  parameter int unsigned CNT_W      = 8
) (
  input logic              clk,
  input logic              rst_n,
  clk_switch_ctrl_if.slave bus
);

  localparam int unsigned     OwnW     = owner_width(NUM_REQ);
  localparam logic [CNT_W-1:0] SettleLd = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] HoldLd   = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [OwnW-1:0]  LastIdx  = OwnW'(NUM_REQ - 1);
  localparam bit               HasHold  = (HOLD_CYC > 0);

  state_e             state_q;
  logic [CNT_W-1:0]   timer_q;
  logic [OwnW-1:0]    ptr_q;
  logic [OwnW-1:0]    owner_q;
  logic               tgt_q;
  logic               switched_q;
  logic               sel_q;
  logic               cur_src_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               busy_q;

  logic               grant_valid;
  logic [OwnW-1:0]    grant_idx;
  logic               grant_src;
  logic [NUM_REQ-1:0] owner_oh;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req_i        (bus.req),
    .ptr_i        (ptr_q),
    .grant_valid_o(grant_valid),
    .grant_o      (grant_idx)
  );

  assign grant_src = bus.req_src[grant_idx];
  assign owner_oh  = NUM_REQ'(1) << owner_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      ptr_q      <= '0;
      owner_q    <= '0;
      tgt_q      <= SRC_CLK0;
      switched_q <= 1'b0;
      sel_q      <= SRC_CLK0;
      cur_src_q  <= SRC_CLK0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            owner_q <= grant_idx;
            tgt_q   <= grant_src;
            ptr_q   <= (grant_idx == LastIdx) ? '0 : grant_idx + OwnW'(1);
            busy_q  <= 1'b1;
            if (grant_src != cur_src_q) begin
              sel_q      <= grant_src;
              timer_q    <= SettleLd;
              switched_q <= 1'b1;
              state_q    <= StSwitch;
            end else begin
              switched_q <= 1'b0;
              state_q    <= StDone;
            end
          end
        end
        StSwitch: begin
          if (timer_q == '0) begin
            state_q <= StDone;
          end else begin
            timer_q <= timer_q - CNT_W'(1);
          end
        end
        StDone: begin
          // Ack and cur_src become visible together, one edge after DONE.
          ack_q     <= owner_oh;
          cur_src_q <= tgt_q;
          if (switched_q && HasHold) begin
            timer_q <= HoldLd;
            state_q <= StHold;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StHold: begin
          if (timer_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q - CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.ack     = ack_q;
  assign bus.sel     = sel_q;
  assign bus.cur_src = cur_src_q;
  assign bus.busy    = busy_q;
  assign bus.owner   = owner_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed self-checking bench for clk_switch_ctrl (SETTLE_CYC=8, HOLD_CYC=16,
// NUM_REQ=4); outputs are sampled 1 time unit after each rising edge.
module tb_clk_switch_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  clk_switch_ctrl_if #(.NUM_REQ(4)) bus ();

  clk_switch_ctrl #(
    .NUM_REQ   (4),
    .SETTLE_CYC(8),
    .HOLD_CYC  (16),
    .CNT_W     (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ack must stay low for lat-1 edges after the grant edge, then equal exp.
  task automatic expect_ack(input string tag, input logic [3:0] exp, input int lat);
    for (int i = 1; i < lat; i++) begin
      tick();
      chk({tag, "_early"}, 32'(bus.ack), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    end
    tick();
    chk(tag, 32'(bus.ack), 32'(exp));
  endtask

  // Called right after the ack edge of a switch: 15 more HOLD edges, then IDLE.
  task automatic hold_wait(input string tag);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk({tag, "_hold_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_hold_ack"}, 32'(bus.ack), 32'd0);
    end
    tick();
    chk({tag, "_hold_end"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.req_src = '0;

    // Reset state
    tick();
    tick();
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_cur_src", 32'(bus.cur_src), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd0);
    rst_n = 1'b1;
    tick();

    // T1: req0 -> clk1, full switch with settle and hold
    bus.req     = 4'b0001;
    bus.req_src = 4'b0001;
    tick();
    chk("t1_sel", 32'(bus.sel), 32'd1);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_owner", 32'(bus.owner), 32'd0);
    chk("t1_cur_src_pre", 32'(bus.cur_src), 32'd0);
    expect_ack("t1_ack", 4'b0001, 9);
    chk("t1_cur_src", 32'(bus.cur_src), 32'd1);
    bus.req = '0;
    hold_wait("t1");

    // T2: req2 -> clk1 while already on clk1: ack in 1 cycle, no hold
    bus.req     = 4'b0100;
    bus.req_src = 4'b0100;
    tick();
    chk("t2_owner", 32'(bus.owner), 32'd2);
    chk("t2_busy", 32'(bus.busy), 32'd1);
    expect_ack("t2_ack", 4'b0100, 1);
    chk("t2_sel", 32'(bus.sel), 32'd1);
    chk("t2_busy_low", 32'(bus.busy), 32'd0);
    bus.req = '0;
    tick();
    chk("t2_busy_low2", 32'(bus.busy), 32'd0);

    // T3: all four request clk0; pointer is 3 here so order is 3,0,1,2
    bus.req     = 4'b1111;
    bus.req_src = 4'b0000;
    tick();
    chk("t3_owner3", 32'(bus.owner), 32'd3);
    chk("t3_sel", 32'(bus.sel), 32'd0);
    expect_ack("t3_ack3", 4'b1000, 9);
    chk("t3_cur_src", 32'(bus.cur_src), 32'd0);
    bus.req = 4'b0111;
    hold_wait("t3");
    chk("t3_owner_held", 32'(bus.owner), 32'd3);
    tick();
    chk("t3_owner0", 32'(bus.owner), 32'd0);
    expect_ack("t3_ack0", 4'b0001, 1);
    bus.req = 4'b0110;
    tick();
    chk("t3_owner1", 32'(bus.owner), 32'd1);
    expect_ack("t3_ack1", 4'b0010, 1);
    bus.req = 4'b0100;
    tick();
    chk("t3_owner2", 32'(bus.owner), 32'd2);
    expect_ack("t3_ack2", 4'b0100, 1);
    chk("t3_sel_end", 32'(bus.sel), 32'd0);
    bus.req = '0;
    tick();
    chk("t3_idle", 32'(bus.busy), 32'd0);

    // T4 setup: same-source grant to req1 moves the pointer to 2
    bus.req     = 4'b0010;
    bus.req_src = 4'b0000;
    tick();
    chk("t4_setup_owner", 32'(bus.owner), 32'd1);
    expect_ack("t4_setup_ack", 4'b0010, 1);
    bus.req = '0;
    // T4: req1 -> clk1, req3 -> clk0, pointer 2: req3 first, then req1 switches
    bus.req     = 4'b1010;
    bus.req_src = 4'b0010;
    tick();
    chk("t4_owner3", 32'(bus.owner), 32'd3);
    chk("t4_sel0", 32'(bus.sel), 32'd0);
    expect_ack("t4_ack3", 4'b1000, 1);
    bus.req = 4'b0010;
    tick();
    chk("t4_owner1", 32'(bus.owner), 32'd1);
    chk("t4_sel1", 32'(bus.sel), 32'd1);
    expect_ack("t4_ack1", 4'b0010, 9);
    chk("t4_cur_src", 32'(bus.cur_src), 32'd1);
    bus.req = '0;
    hold_wait("t4");

    // T6: req2 -> clk0, dropped mid-switch; switch still completes and hold applies
    bus.req     = 4'b0100;
    bus.req_src = 4'b0000;
    tick();
    chk("t6_owner", 32'(bus.owner), 32'd2);
    chk("t6_sel", 32'(bus.sel), 32'd0);
    tick();
    bus.req = '0;
    expect_ack("t6_ack", 4'b0100, 8);
    chk("t6_cur_src", 32'(bus.cur_src), 32'd0);
    bus.req = 4'b0001;
    hold_wait("t6");
    chk("t6_owner_held", 32'(bus.owner), 32'd2);
    tick();
    chk("t6_next_owner", 32'(bus.owner), 32'd0);
    chk("t6_next_busy", 32'(bus.busy), 32'd1);
    expect_ack("t6_next_ack", 4'b0001, 1);
    bus.req = '0;

    // T5: reset while SWITCH has timer=4 abandons the switch without ack
    bus.req     = 4'b0010;
    bus.req_src = 4'b0010;
    tick();
    chk("t5_owner", 32'(bus.owner), 32'd1);
    chk("t5_sel", 32'(bus.sel), 32'd1);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("t5_rst_sel", 32'(bus.sel), 32'd0);
    chk("t5_rst_cur_src", 32'(bus.cur_src), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_ack", 32'(bus.ack), 32'd0);
    chk("t5_rst_owner", 32'(bus.owner), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t5_regrant_owner", 32'(bus.owner), 32'd1);
    chk("t5_regrant_sel", 32'(bus.sel), 32'd1);
    chk("t5_regrant_busy", 32'(bus.busy), 32'd1);
    expect_ack("t5_ack", 4'b0010, 9);
    chk("t5_cur_src", 32'(bus.cur_src), 32'd1);
    bus.req = '0;
    tick();
    chk("t5_ack_clear", 32'(bus.ack), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
